// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming big-endian bytes into instruction memory.
// Optional trailer checksum: define IMEM_LOADER_CHECKSUM_EN.
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [32:0]   CAP = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [1:0]        byte_idx;
  logic [23:0]       shift;
  logic [ADDR_W:0]   len;
  logic [31:0]       word;
  logic              xfer;
  logic              last_byte;
  logic              start_ok;
  logic              hdr_bad;
  logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       acc;
`endif

  assign in_ready  = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign busy      = in_ready || (state == S_DRAIN);
  assign xfer      = in_valid && in_ready;
  assign last_byte = xfer && (byte_idx == 2'd3);
  // Word being completed by the byte on the bus this cycle.
  assign word      = {shift, in_data};
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign hdr_bad   = (word == 32'd0) || ({1'b0, word} > CAP);
  assign last_word = ((word_count + ONE) == len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_ok) state_nx = S_LEN;
      end
      S_LEN: begin
        if (last_byte) state_nx = hdr_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        if (last_byte && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nx = S_CHK;
`else
          state_nx = S_DRAIN;
`endif
        end
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (last_byte) state_nx = (word == acc) ? S_DRAIN : S_ERROR;
`else
        state_nx = S_ERROR;
`endif
      end
      S_DRAIN: state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status flags lag the state by one cycle so done only follows a settled write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else if (start_ok) begin
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      cpu_hold <= (state != S_DONE);
      done     <= (state == S_DONE);
      error    <= (state == S_ERROR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx   <= 2'd0;
      shift      <= 24'd0;
      len        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc        <= 32'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        byte_idx   <= 2'd0;
        word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc        <= 32'd0;
`endif
      end
      if (xfer) begin
        byte_idx <= byte_idx + 2'd1;
        shift    <= word[23:0];
      end
      if (last_byte && (state == S_LEN)) begin
        len <= word[ADDR_W:0];
      end
      if (last_byte && (state == S_DATA)) begin
        mem_we     <= 1'b1;
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_wdata  <= word;
        word_count <= word_count + ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc        <= acc ^ word;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven.
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 4;
`else
  localparam int CHK_EXTRA = 0;
`endif

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          start_cyc = 0;
  int          end_cyc = 0;
  logic [63:0] sb[$];
  logic [31:0] img[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every write strobe is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      logic [63:0] e;
      wr_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_we", 64'(mem_addr), 64'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("we_addr", 64'(mem_addr), 64'(e[63:32]));
        check("we_data", 64'(mem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit ok;
    if (stall) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 64'd0, 64'd1);
    else @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], stall);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (done || error) begin
        seen = 1'b1;
        break;
      end
    end
    end_cyc = cyc;
    if (!seen) check("end_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Drives header, the first nw words of img and (if built) a trailer.
  task automatic run_load(input logic [31:0] hdr, input int nw, input bit stall, input bit bad_chk);
    logic [31:0] acc;
    acc = 32'd0;
    do_start();
    send_word(hdr, stall);
    for (int i = 0; i < nw; i++) begin
      sb.push_back({32'(i), img[i]});
      acc = acc ^ img[i];
      send_word(img[i], stall);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (nw > 0) send_word(bad_chk ? 32'd0 : acc, stall);
`endif
    wait_end();
  endtask

  task automatic basic_image();
    img.delete();
    img.push_back(32'h1234_5678);
    img.push_back(32'h9ABC_DEF0);
    img.push_back(32'h0BAD_F00D);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    int base;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    rst = 1'b1;

    // Idle after reset without a start pulse.
    base = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_cpu_hold", 64'(cpu_hold), 64'd1);
      check("idle_in_ready", 64'(in_ready), 64'd0);
    end
    check("idle_writes", 64'(wr_cnt - base), 64'd0);
    @(posedge clk); #1;

    // Basic load with an always-valid source.
    basic_image();
    base = wr_cnt;
    run_load(32'd2, 2, 1'b0, 1'b0);
    check("basic_latency", 64'(end_cyc - start_cyc), 64'(4 + 4*2 + 2 + CHK_EXTRA));
    check("basic_done", 64'(done), 64'd1);
    check("basic_error", 64'(error), 64'd0);
    check("basic_cpu_hold", 64'(cpu_hold), 64'd0);
    check("basic_word_count", 64'(word_count), 64'd2);
    check("basic_writes", 64'(wr_cnt - base), 64'd2);
    check("basic_sb_empty", 64'(sb.size()), 64'd0);
    check("basic_busy", 64'(busy), 64'd0);

    // Same image, source stalling between bytes; restarted from DONE.
    base = wr_cnt;
    run_load(32'd2, 2, 1'b1, 1'b0);
    check("stall_done", 64'(done), 64'd1);
    check("stall_word_count", 64'(word_count), 64'd2);
    check("stall_writes", 64'(wr_cnt - base), 64'd2);
    check("stall_sb_empty", 64'(sb.size()), 64'd0);

    // Rejected headers: zero and one past capacity.
    base = wr_cnt;
    run_load(32'd0, 0, 1'b0, 1'b0);
    check("hdr0_error", 64'(error), 64'd1);
    check("hdr0_done", 64'(done), 64'd0);
    check("hdr0_cpu_hold", 64'(cpu_hold), 64'd1);
    check("hdr0_in_ready", 64'(in_ready), 64'd0);
    check("hdr0_writes", 64'(wr_cnt - base), 64'd0);
    base = wr_cnt;
    run_load(32'((1 << ADDR_W) + 1), 0, 1'b0, 1'b0);
    check("hdrbig_error", 64'(error), 64'd1);
    check("hdrbig_cpu_hold", 64'(cpu_hold), 64'd1);
    check("hdrbig_writes", 64'(wr_cnt - base), 64'd0);
    check("hdrbig_word_count", 64'(word_count), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong trailer: both words land, then the load is rejected.
    base = wr_cnt;
    run_load(32'd2, 2, 1'b0, 1'b1);
    check("chk_error", 64'(error), 64'd1);
    check("chk_done", 64'(done), 64'd0);
    check("chk_cpu_hold", 64'(cpu_hold), 64'd1);
    check("chk_writes", 64'(wr_cnt - base), 64'd2);
`endif

    // Full-capacity image: word_count must reach 2^ADDR_W without wrapping.
    img.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) img.push_back(32'hA500_0000 ^ (32'(i) * 32'h0001_0203));
    base = wr_cnt;
    run_load(32'(1 << ADDR_W), 1 << ADDR_W, 1'b0, 1'b0);
    check("full_done", 64'(done), 64'd1);
    check("full_word_count", 64'(word_count), 64'(1 << ADDR_W));
    check("full_writes", 64'(wr_cnt - base), 64'(1 << ADDR_W));

    // Reset in the middle of a 3-word load, then a clean reload.
    basic_image();
    do_start();
    send_word(32'd3, 1'b0);
    sb.push_back({32'd0, img[0]});
    send_word(img[0], 1'b0);
    send_byte(img[1][31:24], 1'b0);
    send_byte(img[1][23:16], 1'b0);
    base = wr_cnt;
    #3;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (3) @(negedge clk);
    check("midrst_hold_cpu", 64'(cpu_hold), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_writes", 64'(wr_cnt - base), 64'd0);
    check("midrst_sb_empty", 64'(sb.size()), 64'd0);
    check("midrst_word_count", 64'(word_count), 64'd0);
    @(posedge clk); #1;
    base = wr_cnt;
    run_load(32'd2, 2, 1'b0, 1'b0);
    check("reload_done", 64'(done), 64'd1);
    check("reload_cpu_hold", 64'(cpu_hold), 64'd0);
    check("reload_word_count", 64'(word_count), 64'd2);
    check("reload_writes", 64'(wr_cnt - base), 64'd2);
    check("reload_sb_empty", 64'(sb.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
